alu_ctl_md: RTL

ALU_CTL_MD -- requirements
Module: alu_ctl_md

---
 rtl/alu_ctl_md.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctl_md.sv
// ALU control decoder with an iterative multiply/divide engine and HI/LO registers.
// Define ALU_CTL_MD_DIV_EN to build the divider; otherwise div/divu decode as illegal.
module alu_ctl_md #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ALUC_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    output logic [ALUC_W-1:0] aluc,
    output logic              illegal,
    output logic              md_busy,
    output logic [WIDTH-1:0]  md_rd,
    output logic              md_rd_valid,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;
    typedef enum logic [2:0] {MdNone, MdMthi, MdMtlo, MdMfhi, MdMflo, MdMul, MdDiv} md_op_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]    opb_q, opb_d;
    logic                neg_lo_q, neg_lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d, lo_q, lo_d;
    logic [ALUC_W-1:0]   aluc_q, aluc_d;
    logic                illegal_q, illegal_d;
    logic [WIDTH-1:0]    md_rd_q, md_rd_d;
    logic                md_rd_valid_q, md_rd_valid_d;

`ifdef ALU_CTL_MD_DIV_EN
    logic                is_div_q, is_div_d;
    logic                neg_hi_q, neg_hi_d;
    logic                dvz_q, dvz_d;
    logic [WIDTH-1:0]    dvd_q, dvd_d;
    logic [WIDTH:0]      div_sh;
    logic                div_ge;
    logic [WIDTH-1:0]    div_rem;
    logic [2*WIDTH-1:0]  div_next;
`endif

    logic [ALUC_W-1:0]   aluc_dec;
    logic                illegal_dec;
    md_op_e              md_op_dec;
    logic                md_signed_dec;
    logic                accept;
    logic [WIDTH-1:0]    abs_a, abs_b;
    logic [WIDTH:0]      mul_sum;
    logic [2*WIDTH-1:0]  mul_next;

    assign md_busy     = (state_q != StIdle);
    assign in_ready    = ~md_busy;
    assign accept      = in_valid & in_ready;
    assign aluc        = aluc_q;
    assign illegal     = illegal_q;
    assign md_rd       = md_rd_q;
    assign md_rd_valid = md_rd_valid_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Instruction decode
    always_comb begin
        aluc_dec      = '0;
        illegal_dec   = 1'b0;
        md_op_dec     = MdNone;
        md_signed_dec = 1'b0;
        if (op == 6'b000000) begin
            case (func)
                6'b100000: aluc_dec = ALUC_W'(0);
                6'b100001: aluc_dec = ALUC_W'(1);
                6'b100010: aluc_dec = ALUC_W'(2);
                6'b100011: aluc_dec = ALUC_W'(3);
                6'b100100: aluc_dec = ALUC_W'(4);
                6'b100101: aluc_dec = ALUC_W'(5);
                6'b100110: aluc_dec = ALUC_W'(6);
                6'b100111: aluc_dec = ALUC_W'(7);
                6'b101010: aluc_dec = ALUC_W'(8);
                6'b101011: aluc_dec = ALUC_W'(9);
                6'b000000, 6'b000100: aluc_dec = ALUC_W'(10);
                6'b000010, 6'b000110: aluc_dec = ALUC_W'(11);
                6'b000011, 6'b000111: aluc_dec = ALUC_W'(12);
                6'b010000: begin aluc_dec = ALUC_W'(15); md_op_dec = MdMfhi; end
                6'b010001: begin aluc_dec = ALUC_W'(15); md_op_dec = MdMthi; end
                6'b010010: begin aluc_dec = ALUC_W'(15); md_op_dec = MdMflo; end
                6'b010011: begin aluc_dec = ALUC_W'(15); md_op_dec = MdMtlo; end
                6'b011000, 6'b011001: begin
                    aluc_dec      = ALUC_W'(15);
                    md_op_dec     = MdMul;
                    md_signed_dec = ~func[0];
                end
`ifdef ALU_CTL_MD_DIV_EN
                6'b011010, 6'b011011: begin
                    aluc_dec      = ALUC_W'(15);
                    md_op_dec     = MdDiv;
                    md_signed_dec = ~func[0];
                end
`endif
                default: illegal_dec = 1'b1;
            endcase
        end else begin
            case (op)
                6'b001000: aluc_dec = ALUC_W'(0);
                6'b001001: aluc_dec = ALUC_W'(1);
                6'b001100: aluc_dec = ALUC_W'(4);
                6'b001101: aluc_dec = ALUC_W'(5);
                6'b001110: aluc_dec = ALUC_W'(6);
                6'b001010: aluc_dec = ALUC_W'(8);
                6'b001011: aluc_dec = ALUC_W'(9);
                6'b001111: aluc_dec = ALUC_W'(14);
                default:   illegal_dec = 1'b1;
            endcase
        end
    end

    // The engine works on magnitudes; signs are restored in StFix
    assign abs_a = (md_signed_dec && rs_val[WIDTH-1]) ? (~rs_val + 1'b1) : rs_val;
    assign abs_b = (md_signed_dec && rt_val[WIDTH-1]) ? (~rt_val + 1'b1) : rt_val;

    // Shift-add: acc holds {partial product, unconsumed multiplier bits}
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef ALU_CTL_MD_DIV_EN
    // Restoring divide: acc holds {remainder, dividend/quotient bits}
    assign div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (div_sh >= {1'b0, opb_q});
    assign div_rem  = div_ge ? (div_sh[WIDTH-1:0] - opb_q) : div_sh[WIDTH-1:0];
    assign div_next = {div_rem, acc_q[WIDTH-2:0], div_ge};
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        opb_d         = opb_q;
        neg_lo_d      = neg_lo_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        aluc_d        = aluc_q;
        illegal_d     = illegal_q;
        md_rd_d       = md_rd_q;
        md_rd_valid_d = 1'b0;
`ifdef ALU_CTL_MD_DIV_EN
        is_div_d      = is_div_q;
        neg_hi_d      = neg_hi_q;
        dvz_d         = dvz_q;
        dvd_d         = dvd_q;
`endif
        if (accept) begin
            aluc_d    = aluc_dec;
            illegal_d = illegal_dec;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (md_op_dec)
                        MdMthi: hi_d = rs_val;
                        MdMtlo: lo_d = rs_val;
                        MdMfhi: begin md_rd_d = hi_q; md_rd_valid_d = 1'b1; end
                        MdMflo: begin md_rd_d = lo_q; md_rd_valid_d = 1'b1; end
                        MdMul: begin
                            state_d  = StRun;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            opb_d    = abs_b;
                            neg_lo_d = md_signed_dec & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
`ifdef ALU_CTL_MD_DIV_EN
                            is_div_d = 1'b0;
`endif
                        end
`ifdef ALU_CTL_MD_DIV_EN
                        MdDiv: begin
                            state_d  = StRun;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            opb_d    = abs_b;
                            neg_lo_d = md_signed_dec & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                            is_div_d = 1'b1;
                            neg_hi_d = md_signed_dec & rs_val[WIDTH-1];
                            dvz_d    = (rt_val == '0);
                            dvd_d    = rs_val;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                acc_d = mul_next;
`ifdef ALU_CTL_MD_DIV_EN
                if (is_div_q) acc_d = div_next;
`endif
                if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                {hi_d, lo_d} = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
`ifdef ALU_CTL_MD_DIV_EN
                if (is_div_q) begin
                    if (dvz_q) begin
                        lo_d = '1;
                        hi_d = dvd_q;
                    end else begin
                        lo_d = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
                        hi_d = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                                        : acc_q[2*WIDTH-1:WIDTH];
                    end
                end
`endif
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            acc_q         <= '0;
            opb_q         <= '0;
            neg_lo_q      <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
            aluc_q        <= '0;
            illegal_q     <= 1'b0;
            md_rd_q       <= '0;
            md_rd_valid_q <= 1'b0;
`ifdef ALU_CTL_MD_DIV_EN
            is_div_q      <= 1'b0;
            neg_hi_q      <= 1'b0;
            dvz_q         <= 1'b0;
            dvd_q         <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acc_q         <= acc_d;
            opb_q         <= opb_d;
            neg_lo_q      <= neg_lo_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
            aluc_q        <= aluc_d;
            illegal_q     <= illegal_d;
            md_rd_q       <= md_rd_d;
            md_rd_valid_q <= md_rd_valid_d;
`ifdef ALU_CTL_MD_DIV_EN
            is_div_q      <= is_div_d;
            neg_hi_q      <= neg_hi_d;
            dvz_q         <= dvz_d;
            dvd_q         <= dvd_d;
`endif
        end
    end

endmodule
